// File: rtl/quad_encoder_regs.sv
// Quadrature decoder for two encoders (LR, UD). It keeps signed 16-bit position counts
// and sticky illegal-transition flags. The dispatcher can preload the counts and clear
// the flags through write strobes.
module quad_encoder_regs #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [15:0] ADDR_LR     = 16'hFFF0,
  parameter logic [15:0] ADDR_UD     = 16'hFFF1,
  parameter logic [15:0] ADDR_STAT   = 16'hFFF2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        lrA,
  input  logic        lrB,
  input  logic        udA,
  input  logic        udB,
  input  logic [15:0] AddressIn,
  input  logic        weIn,
  input  logic [15:0] WriteDataIn,
  output logic [15:0] encLR,
  output logic [15:0] encUD,
  output logic [15:0] encStatus
);

  localparam int unsigned PrimeCycles = SYNC_STAGES + 1;
  localparam int unsigned PrimeW      = $clog2(PrimeCycles + 1);
  localparam logic [PrimeW-1:0] PrimeDone = PrimeW'(PrimeCycles);

  // Each stage holds {lrA, lrB, udA, udB}.
  logic [3:0]        r_sync [SYNC_STAGES];
  logic [1:0]        r_lr_prev, r_ud_prev;
  logic [PrimeW-1:0] r_prime_cnt;
  logic [15:0]       r_enc_lr, r_enc_ud;
  logic [1:0]        r_err;

  logic [1:0]  w_lr_cur, w_ud_cur;
  logic        w_primed;
  logic [2:0]  w_lr_dec, w_ud_dec;
  logic        w_wr_lr, w_wr_ud, w_wr_stat;
  logic [15:0] w_enc_lr_d, w_enc_ud_d;
  logic [1:0]  w_err_d;

  // Returns {err, dec, inc} for one prev->cur phase transition ({A,B} encoding).
  function automatic logic [2:0] decode(input logic [1:0] prev, input logic [1:0] cur);
    logic [2:0] res;
    res = 3'b000;
    unique case ({prev, cur})
      4'b0001, 4'b0111, 4'b1110, 4'b1000: res = 3'b001;
      4'b0100, 4'b1101, 4'b1011, 4'b0010: res = 3'b010;
      4'b0011, 4'b1100, 4'b0110, 4'b1001: res = 3'b100;
      default:                            res = 3'b000;
    endcase
    return res;
  endfunction

  assign w_lr_cur  = r_sync[SYNC_STAGES-1][3:2];
  assign w_ud_cur  = r_sync[SYNC_STAGES-1][1:0];
  assign w_primed  = (r_prime_cnt == PrimeDone);
  assign w_wr_lr   = weIn && (AddressIn == ADDR_LR);
  assign w_wr_ud   = weIn && (AddressIn == ADDR_UD);
  assign w_wr_stat = weIn && (AddressIn == ADDR_STAT);

  // Next-state for the counts and error flags. A write overrides a decode step on the
  // same cycle, and a new error overrides a clear on the same cycle.
  always_comb begin
    w_lr_dec   = 3'b000;
    w_ud_dec   = 3'b000;
    w_enc_lr_d = r_enc_lr;
    w_enc_ud_d = r_enc_ud;
    w_err_d    = r_err;
    if (w_primed) begin
      w_lr_dec = decode(r_lr_prev, w_lr_cur);
      w_ud_dec = decode(r_ud_prev, w_ud_cur);
    end
    if (w_lr_dec[0])      w_enc_lr_d = r_enc_lr + 16'd1;
    else if (w_lr_dec[1]) w_enc_lr_d = r_enc_lr - 16'd1;
    if (w_ud_dec[0])      w_enc_ud_d = r_enc_ud + 16'd1;
    else if (w_ud_dec[1]) w_enc_ud_d = r_enc_ud - 16'd1;
    if (w_wr_lr) w_enc_lr_d = WriteDataIn;
    if (w_wr_ud) w_enc_ud_d = WriteDataIn;
    if (w_wr_stat) w_err_d = r_err & ~WriteDataIn[1:0];
    w_err_d = w_err_d | {w_ud_dec[2], w_lr_dec[2]};
  end

  // Input synchronizers. The decode logic only looks at the last stage.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(SYNC_STAGES); i++) r_sync[i] <= 4'b0000;
    end else begin
      r_sync[0] <= {lrA, lrB, udA, udB};
      for (int i = 1; i < int'(SYNC_STAGES); i++) r_sync[i] <= r_sync[i-1];
    end
  end

  // Priming counter, previous-phase tracking, counts and status.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_prime_cnt <= '0;
      r_lr_prev   <= 2'b00;
      r_ud_prev   <= 2'b00;
      r_enc_lr    <= 16'h0000;
      r_enc_ud    <= 16'h0000;
      r_err       <= 2'b00;
    end else begin
      if (!w_primed) r_prime_cnt <= r_prime_cnt + PrimeW'(1);
      r_lr_prev <= w_lr_cur;
      r_ud_prev <= w_ud_cur;
      r_enc_lr  <= w_enc_lr_d;
      r_enc_ud  <= w_enc_ud_d;
      r_err     <= w_err_d;
    end
  end

  assign encLR     = r_enc_lr;
  assign encUD     = r_enc_ud;
  assign encStatus = {14'b0, r_err};

endmodule
